// File: rtl/mem_amo_pkg.sv
// Shared definitions for the atomic-capable SRAM bank slave.
//   - AXI5 ATOP field decode constants (same values as axi_pkg)
//   - amo_op_e   : internal atomic operation selector
//   - amo_state_e: controller FSM states
//   - amo_compute: width-generic atomic arithmetic on zero-extended words
package mem_amo_pkg;

  // atop[5:4]: transaction class
  localparam logic [1:0] ATOP_NONE        = 2'b00;
  localparam logic [1:0] ATOP_ATMSTORE    = 2'b01;
  localparam logic [1:0] ATOP_ATMLOAD     = 2'b10;
  localparam logic [1:0] ATOP_ATMSWAP_CMP = 2'b11;

  // Full encodings inside the swap/compare class
  localparam logic [5:0] ATOP_ATMSWAP = 6'b110000;
  localparam logic [5:0] ATOP_ATMCMP  = 6'b110001;

  // atop[2:0]: arithmetic op for store/load classes (atop[3] is endianness)
  localparam logic [2:0] ATOP_ADD  = 3'b000;
  localparam logic [2:0] ATOP_CLR  = 3'b001;
  localparam logic [2:0] ATOP_EOR  = 3'b010;
  localparam logic [2:0] ATOP_SET  = 3'b011;
  localparam logic [2:0] ATOP_SMAX = 3'b100;
  localparam logic [2:0] ATOP_SMIN = 3'b101;
  localparam logic [2:0] ATOP_UMAX = 3'b110;
  localparam logic [2:0] ATOP_UMIN = 3'b111;

  // Arithmetic ops keep their atop[2:0] code so decode is a plain zero-extend.
  typedef enum logic [3:0] {
    AMO_ADD  = {1'b0, ATOP_ADD},
    AMO_CLR  = {1'b0, ATOP_CLR},
    AMO_EOR  = {1'b0, ATOP_EOR},
    AMO_SET  = {1'b0, ATOP_SET},
    AMO_SMAX = {1'b0, ATOP_SMAX},
    AMO_SMIN = {1'b0, ATOP_SMIN},
    AMO_UMAX = {1'b0, ATOP_UMAX},
    AMO_UMIN = {1'b0, ATOP_UMIN},
    AMO_SWAP = 4'h8
  } amo_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    AMO_WB = 1'b1
  } amo_state_e;

  // Widest bank the helper supports; callers zero-extend into this and
  // cast the result back to their own width, so unused upper logic folds away.
  localparam int unsigned AMO_MAX_W = 1024;
  typedef logic [AMO_MAX_W-1:0] amo_word_t;

  // Signed compare is done as an unsigned compare with the sign bit of the
  // real width flipped, which keeps the function independent of DataWidth.
  function automatic amo_word_t amo_compute(input amo_op_e     op,
                                            input amo_word_t   old,
                                            input amo_word_t   operand,
                                            input int unsigned width);
    amo_word_t sign_bit;
    amo_word_t result;
    logic      u_old_gt;
    logic      s_old_gt;
    sign_bit = amo_word_t'(1) << (width - 1);
    u_old_gt = old > operand;
    s_old_gt = (old ^ sign_bit) > (operand ^ sign_bit);
    case (op)
      AMO_ADD:  result = old + operand;
      AMO_CLR:  result = old & ~operand;
      AMO_EOR:  result = old ^ operand;
      AMO_SET:  result = old | operand;
      AMO_SMAX: result = s_old_gt ? old : operand;
      AMO_SMIN: result = s_old_gt ? operand : old;
      AMO_UMAX: result = u_old_gt ? old : operand;
      AMO_UMIN: result = u_old_gt ? operand : old;
      AMO_SWAP: result = operand;
      default:  result = old;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_amo_alu.sv
// Combinational atomic ALU: computes the new word from the old SRAM word and
// the registered operand, then keeps the old byte wherever strb is 0.
// Ports:
//   op       in  atomic operation
//   old_data in  current SRAM word
//   operand  in  atomic operand
//   strb     in  byte enables
//   new_data out word to write back
module mem_amo_alu
  import mem_amo_pkg::*;
#(
  parameter  int unsigned DataWidth = 32,
  localparam int unsigned StrbWidth = DataWidth / 8
) (
  input  amo_op_e              op,
  input  logic [DataWidth-1:0] old_data,
  input  logic [DataWidth-1:0] operand,
  input  logic [StrbWidth-1:0] strb,
  output logic [DataWidth-1:0] new_data
);

  logic [DataWidth-1:0] result;

  assign result = DataWidth'(amo_compute(op, amo_word_t'(old_data),
                                         amo_word_t'(operand), DataWidth));

  // NOTE: every variable written here gets a value on every path (the loop
  // covers all bytes), so no latch can be inferred.
  always_comb begin
    for (int b = 0; b < StrbWidth; b++) begin
      new_data[8*b +: 8] = strb[b] ? result[8*b +: 8] : old_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/mem_amo_sram.sv
// Single-bank memory-stream slave in front of a 1-cycle-read SRAM macro.
// Plain reads/writes pass straight through at one per cycle; AXI5 atomics
// read in IDLE and write back the merged result in AMO_WB (grant low there).
// Every grant produces exactly one rvalid pulse one cycle later.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   mem_req_i/mem_gnt_o            request handshake
//   mem_addr_i/wdata_i/strb_i      byte address, write data/operand, byte enables
//   mem_atop_i/mem_we_i            atomic opcode, write enable
//   mem_rvalid_o/mem_rdata_o       response (old value for atomics, 0 for writes)
//   sram_*                         SRAM macro interface
module mem_amo_sram
  import mem_amo_pkg::*;
#(
  parameter  int unsigned AddrWidth     = 32,
  parameter  int unsigned DataWidth     = 32,
  parameter  int unsigned NumWords      = 1024,
  localparam int unsigned StrbWidth     = DataWidth / 8,
  localparam int unsigned WordAddrWidth = $clog2(NumWords)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     mem_req_i,
  output logic                     mem_gnt_o,
  input  logic [AddrWidth-1:0]     mem_addr_i,
  input  logic [DataWidth-1:0]     mem_wdata_i,
  input  logic [StrbWidth-1:0]     mem_strb_i,
  input  logic [5:0]               mem_atop_i,
  input  logic                     mem_we_i,
  output logic                     mem_rvalid_o,
  output logic [DataWidth-1:0]     mem_rdata_o,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [WordAddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0]     sram_wdata_o,
  output logic [StrbWidth-1:0]     sram_be_o,
  input  logic [DataWidth-1:0]     sram_rdata_i
);

  localparam int unsigned ByteOffset = $clog2(StrbWidth);

  amo_state_e               state_q, state_d;
  logic [1:0]               atop_kind;
  logic                     is_cmp, is_amo, is_write, granted;
  amo_op_e                  op_d, amo_op_q;
  logic [DataWidth-1:0]     amo_operand_q, amo_wdata;
  logic [StrbWidth-1:0]     amo_strb_q;
  logic [WordAddrWidth-1:0] req_word, amo_addr_q;
  logic                     rvalid_q, rdata_zero_q;
  logic                     unused_addr_bits;

  // Byte offset and bits above the bank depth are intentionally dropped.
  assign unused_addr_bits = ^mem_addr_i;
  assign req_word         = mem_addr_i[ByteOffset +: WordAddrWidth];

  // Compare is unsupported and degrades to a plain read, even with we=1.
  assign atop_kind = mem_atop_i[5:4];
  assign is_cmp    = (mem_atop_i == ATOP_ATMCMP);
  assign is_amo    = (atop_kind != ATOP_NONE) && !is_cmp;
  assign is_write  = (atop_kind == ATOP_NONE) && mem_we_i;
  assign op_d      = (atop_kind == ATOP_ATMSWAP_CMP) ? AMO_SWAP
                                                     : amo_op_e'({1'b0, mem_atop_i[2:0]});
  assign granted   = mem_req_i && mem_gnt_o;

  mem_amo_alu #(
    .DataWidth (DataWidth)
  ) u_alu (
    .op       (amo_op_q),
    .old_data (sram_rdata_i),
    .operand  (amo_operand_q),
    .strb     (amo_strb_q),
    .new_data (amo_wdata)
  );

  always_comb begin
    state_d      = state_q;
    mem_gnt_o    = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = req_word;
    sram_wdata_o = mem_wdata_i;
    sram_be_o    = '0;
    case (state_q)
      IDLE: begin
        mem_gnt_o = 1'b1;
        if (mem_req_i) begin
          sram_req_o = 1'b1;
          sram_we_o  = is_write;
          if (is_write) sram_be_o = mem_strb_i;
          if (is_amo)   state_d   = AMO_WB;
        end
      end
      AMO_WB: begin
        // Old word arrives this cycle; write the merged result back now so a
        // request granted next cycle already sees it.
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = amo_addr_q;
        sram_wdata_o = amo_wdata;
        sram_be_o    = amo_strb_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rvalid_q      <= 1'b0;
      rdata_zero_q  <= 1'b0;
      amo_op_q      <= AMO_ADD;
      amo_operand_q <= '0;
      amo_strb_q    <= '0;
      amo_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      rvalid_q     <= granted;
      rdata_zero_q <= granted && is_write;
      if (granted && is_amo) begin
        amo_op_q      <= op_d;
        amo_operand_q <= mem_wdata_i;
        amo_strb_q    <= mem_strb_i;
        amo_addr_q    <= req_word;
      end
    end
  end

  // Read data comes straight from the macro in the response cycle.
  assign mem_rvalid_o = rvalid_q;
  assign mem_rdata_o  = (rvalid_q && !rdata_zero_q) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_mem_amo_sram.sv
module tb_mem_amo_sram;

  localparam int NW = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_strb;
  logic [5:0]  mem_atop;
  logic        sram_req, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [3:0]  sram_be;

  logic        load_mem;
  logic [31:0] sram_mem [NW];
  logic [31:0] ref_mem  [NW];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_amo_sram dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mem_req_i    (mem_req),
    .mem_gnt_o    (mem_gnt),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .mem_strb_i   (mem_strb),
    .mem_atop_i   (mem_atop),
    .mem_we_i     (mem_we),
    .mem_rvalid_o (mem_rvalid),
    .mem_rdata_o  (mem_rdata),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'hDEADBEEF;
      2, 6:    return 32'hFFFFFFFF;
      8, 9:    return 32'hFFFFFFFE;
      10:      return 32'h11111111;
      default: return 32'(i) * 32'h9E3779B9 + 32'h01234567;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_amo(input logic [5:0] atop, input logic [31:0] old,
                                          input logic [31:0] opd);
    if (atop[5:4] == 2'b11) return opd;
    case (atop[2:0])
      3'd0:    return old + opd;
      3'd1:    return old & ~opd;
      3'd2:    return old ^ opd;
      3'd3:    return old | opd;
      3'd4:    return ($signed(old) > $signed(opd)) ? old : opd;
      3'd5:    return ($signed(old) < $signed(opd)) ? old : opd;
      3'd6:    return (old > opd) ? old : opd;
      default: return (old < opd) ? old : opd;
    endcase
  endfunction

  // Behavioural SRAM macro: 1-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < NW; i++) sram_mem[i] <= init_word(i);
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Transaction-level reference: every grant yields one response next cycle;
  // atomics commit only once their write-back cycle has passed under reset-free clock.
  logic        exp_rv = 1'b0;
  logic [31:0] exp_rd;
  logic        commit_pend = 1'b0;
  logic [9:0]  commit_word;
  logic [31:0] commit_val;

  always @(negedge clk) begin
    if (load_mem) for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    if (!rst_n) begin
      exp_rv      = 1'b0;
      commit_pend = 1'b0;
    end else begin
      if (commit_pend) begin
        ref_mem[commit_word] = commit_val;
        commit_pend = 1'b0;
      end
      if (exp_rv || mem_rvalid) begin
        check("rsp_rvalid", 32'(mem_rvalid), 32'(exp_rv));
        if (exp_rv) check("rsp_rdata", mem_rdata, exp_rd);
      end
      exp_rv = 1'b0;
      if (mem_req && mem_gnt) begin
        logic [9:0]  w;
        logic [31:0] old;
        w      = mem_addr[11:2];
        old    = ref_mem[w];
        exp_rv = 1'b1;
        exp_rd = old;
        if (mem_atop[5:4] == 2'b00) begin
          if (mem_we) begin
            ref_mem[w] = merge(old, mem_wdata, mem_strb);
            exp_rd     = 32'h0;
          end
        end else if (mem_atop != 6'b110001) begin
          commit_pend = 1'b1;
          commit_word = w;
          commit_val  = merge(old, ref_amo(mem_atop, old, mem_wdata), mem_strb);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request and holds it until granted; returns at posedge+1 after
  // the grant edge, i.e. in the response cycle. waits = negedges seen incl. grant.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic we, input logic [5:0] atop,
                       output int waits);
    bit g = 1'b0;
    waits     = 0;
    mem_req   = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_strb  = strb;
    mem_we    = we;
    mem_atop  = atop;
    while (!g && waits < 8) begin
      @(negedge clk);
      waits++;
      g = mem_gnt;
      @(posedge clk);
      #1;
    end
    mem_req = 1'b0;
    if (!g) check("grant_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        we;
    logic [5:0]  atop;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    vecs[0]  = '{32'h10, 32'h0,        4'hF, 1'b0, 6'b000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{32'h08, 32'h12345678, 4'h3, 1'b1, 6'b000000, 32'h00000000, 32'hFFFF5678};
    vecs[2]  = '{32'h08, 32'h0,        4'hF, 1'b0, 6'b000000, 32'hFFFF5678, 32'hFFFF5678};
    vecs[3]  = '{32'h18, 32'h00000001, 4'hF, 1'b1, 6'b100000, 32'hFFFFFFFF, 32'h00000000};
    vecs[4]  = '{32'h20, 32'h00000005, 4'hF, 1'b1, 6'b100100, 32'hFFFFFFFE, 32'h00000005};
    vecs[5]  = '{32'h24, 32'h00000005, 4'hF, 1'b1, 6'b100110, 32'hFFFFFFFE, 32'hFFFFFFFE};
    vecs[6]  = '{32'h28, 32'hFFFFFFFF, 4'h0, 1'b1, 6'b010010, 32'h11111111, 32'h11111111};
    vecs[7]  = '{32'h28, 32'h00000000, 4'hF, 1'b1, 6'b110001, 32'h11111111, 32'h11111111};
    vecs[8]  = '{32'h28, 32'h00000000, 4'h0, 1'b1, 6'b000000, 32'h00000000, 32'h11111111};
    vecs[9]  = '{32'h28, 32'h80000000, 4'hF, 1'b1, 6'b011101, 32'h11111111, 32'h80000000};
    vecs[10] = '{32'h10, 32'hFF00FF00, 4'hC, 1'b1, 6'b100001, 32'hDEADBEEF, 32'h00ADBEEF};
    vecs[11] = '{32'h08, 32'h0F0F0F0F, 4'hF, 1'b1, 6'b101010, 32'hFFFF5678, 32'hF0F05977};

    rst_n = 1'b0; load_mem = 1'b1;
    mem_req = 1'b0; mem_addr = '0; mem_wdata = '0; mem_strb = '0; mem_we = 1'b0; mem_atop = '0;
    #12;
    check("reset_rvalid", 32'(mem_rvalid), 32'd0);
    check("reset_rdata", mem_rdata, 32'd0);
    check("reset_gnt", 32'(mem_gnt), 32'd1);
    check("reset_sram_req", 32'(sram_req), 32'd0);
    #10;
    rst_n = 1'b1; load_mem = 1'b0;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].we, vecs[i].atop, w);
      check($sformatf("vec%0d_rvalid", i), 32'(mem_rvalid), 32'd1);
      check($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
      idle(1);
      check($sformatf("vec%0d_word", i), sram_mem[vecs[i].addr[11:2]], vecs[i].exp_word);
    end

    // Swap immediately followed by a read of the same word: stalled one cycle
    issue(32'h30, 32'hA5A5A5A5, 4'hF, 1'b1, 6'b110000, w);
    issue(32'h30, 32'h0, 4'hF, 1'b0, 6'b000000, w);
    check("swap_read_waits", 32'(w), 32'd2);
    check("swap_read_rdata", mem_rdata, 32'hA5A5A5A5);

    // Request offered during AMO_WB then withdrawn: must not be executed
    issue(32'h14, 32'h00000001, 4'hF, 1'b1, 6'b100011, w);
    mem_req = 1'b1; mem_we = 1'b1; mem_atop = '0; mem_addr = 32'h14;
    mem_wdata = 32'h0; mem_strb = 4'hF;
    @(negedge clk);
    check("drop_gnt_in_wb", 32'(mem_gnt), 32'd0);
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    idle(2);
    check("drop_word", sram_mem[5], init_word(5) | 32'h1);

    // Reset during AMO_WB abandons the write-back and its response
    issue(32'h38, 32'h00000001, 4'hF, 1'b1, 6'b100000, w);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_rvalid", 32'(mem_rvalid), 32'd0);
    check("midrst_rdata", mem_rdata, 32'd0);
    check("midrst_gnt", 32'(mem_gnt), 32'd1);
    check("midrst_sram_req", 32'(sram_req), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_word", sram_mem[14], init_word(14));
    issue(32'h38, 32'h0, 4'hF, 1'b0, 6'b000000, w);
    check("midrst_read_waits", 32'(w), 32'd1);
    check("midrst_read_rdata", mem_rdata, init_word(14));

    // Randomized traffic over a small address window to force hazards
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [5:0]  at;
      int          kind;
      a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      kind = $urandom_range(0, 4);
      case (kind)
        0:       at = 6'b000000;
        1:       at = {2'b01, 4'($urandom)};
        2:       at = {2'b10, 4'($urandom)};
        3:       at = 6'b110000;
        default: at = 6'b110001;
      endcase
      issue(a, $urandom, 4'($urandom), 1'($urandom), at, w);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    for (int i = 0; i < 16; i++) check($sformatf("final_word%0d", i), sram_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_amo_sram.md
Name: mem_amo_sram

Overview:
- Single-bank memory-stream slave that sits directly downstream of one bank of the AXI-to-memory converter.
- Consumes req/gnt/addr/wdata/strb/we/atop and drives a synchronous 1-cycle-read SRAM macro.
- Executes AXI5 atomics (ATOP load, store, swap) as an atomic read-modify-write.
- Returns exactly one rvalid pulse per granted request. There is no response backpressure.

Parameters:
- AddrWidth, 32, byte-address width of mem_addr_i.
- DataWidth, 32, bank data width. Must be a power of two, at least 8.
- NumWords, 1024, SRAM depth in words. Only the low $clog2(NumWords) bits of the word index are used.
- localparam StrbWidth = DataWidth/8.
- localparam WordAddrWidth = $clog2(NumWords).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- mem_req_i  in  1  request valid.
- mem_gnt_o  out  1  request accepted this cycle.
- mem_addr_i  in  AddrWidth  byte address.
- mem_wdata_i  in  DataWidth  write data / atomic operand.
- mem_strb_i  in  StrbWidth  byte enables.
- mem_atop_i  in  6  axi_pkg::atop_t.
- mem_we_i  in  1  write enable.
- mem_rvalid_o  out  1  response valid.
- mem_rdata_o  out  DataWidth  read data (old value for atomics).
- sram_req_o  out  1  SRAM access.
- sram_we_o  out  1  SRAM write.
- sram_addr_o  out  WordAddrWidth  word index = mem_addr_i[$clog2(StrbWidth) +: WordAddrWidth].
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  StrbWidth  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data, valid the cycle after a read.

Behaviour:
- Clock and reset: single clock clk_i. Asynchronous active-low reset rst_ni clears FSM to IDLE and all registers. mem_rvalid_o=0, mem_rdata_o=0, mem_gnt_o=1 (comb, IDLE), sram_req_o=0.
- Reset asserted mid-atomic abandons the write-back. No rvalid is produced for that request.
- FSM states:
  - IDLE: mem_gnt_o=1. On mem_req_i, the request is granted and classified:
    - Plain read: atop[5:4]=00, we=0. sram_req=1, we=0.
    - Plain write: atop[5:4]=00, we=1. sram_req=1, we=1, be=strb, wdata passthrough.
    - Atomic: atop[5:4] in {01 store, 10 load, 11 swap}. SRAM read issued. Operand, op, strb and word address are registered. Go to AMO_WB.
    - Compare (atop=6'b110001) is not supported and is executed as a plain read; no write occurs.
  - AMO_WB: mem_gnt_o=0 for exactly this cycle. sram_rdata_i=old is used to compute new. sram_req=1, we=1, be=registered strb, addr=registered address. Return to IDLE.
- Atomic arithmetic (full DataWidth, little-endian; atop[3] ignored):
  - ADD old+op, wrap-around mod 2^DataWidth.
  - CLR old&~op; EOR old^op; SET old|op.
  - SMAX/SMIN signed compare; UMAX/UMIN unsigned compare.
  - SWAP writes op.
  - Bytes with strb=0 are untouched.
- Response timing:
  - mem_rvalid_o is registered high exactly 1 cycle after every grant, including writes and atomics.
  - mem_rdata_o = sram_rdata_i for reads, atomics and compare; 0 for plain writes.
  - An atomic store's rdata is the old value; the consumer discards it.
- Throughput: back-to-back non-atomic requests are granted every cycle. Each atomic costs 2 cycles.
- Ordering: a request granted in the cycle after AMO_WB observes the atomically written value (SRAM write completes in AMO_WB).
- Strobe corner cases:
  - A write with strb=0 still accesses SRAM with be=0 and still gets rvalid.
  - An atomic with strb=0 performs read and no-op write, and returns the old value.
- mem_req_i may drop without grant. Nothing is registered unless granted.

Decomposition:
- Shared package mem_amo_pkg:
  - atop field decode constants (ATOP_NONE, ATOP_ATMSTORE, ATOP_ATMLOAD, ATOP_ATMSWAP, ATOP_ATMCMP, op codes ADD..UMIN); reuse the axi_pkg values.
  - enum amo_state_e {IDLE, AMO_WB}.
  - function amo_compute(op, old, operand).
- One natural sub-module: mem_amo_alu (purely combinational compute + byte merge).

Test Plan:
- Reset then read addr 0x10 (SRAM word 4 = 0xDEADBEEF) -> rvalid 1 cycle after gnt, rdata=0xDEADBEEF; gnt high throughout.
- Write 0x12345678 strb=4'b0011 to 0x8 over 0xFFFFFFFF, then read 0x8 -> be=0011 on SRAM; read returns 0xFFFF5678; both rvalids 1 cycle after grant.
- ATOP load ADD operand 0x1 at word holding 0xFFFFFFFF -> gnt low 1 cycle, rdata=0xFFFFFFFF, SRAM written 0x00000000.
- SMAX operand 0x00000005 vs old 0xFFFFFFFE -> writes 0x00000005; UMAX same values -> writes 0xFFFFFFFE.
- SWAP 0xA5A5A5A5 followed by back-to-back read of same address -> second request stalled one cycle; read returns 0xA5A5A5A5.
- rst_ni asserted during AMO_WB -> no rvalid, outputs at reset values, next read after release granted normally.
